// File: rtl/arp_resolver.sv
// Next-hop IPv4 -> MAC resolver: queries the ARP cache, emits timed ARP requests on a miss, learns replies.
// Optional build macro ARP_RESOLVER_LEARN_ALL_EN: write every accepted ARP rx entry to the cache, not only the awaited reply.
module arp_resolver #(
  parameter int unsigned RETRY_COUNT    = 4,
  parameter int unsigned RETRY_INTERVAL = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        arp_request_valid,
  output logic        arp_request_ready,
  input  logic [31:0] arp_request_ip,
  output logic        arp_response_valid,
  input  logic        arp_response_ready,
  output logic        arp_response_error,
  output logic [47:0] arp_response_mac,
  output logic        cache_query_request_valid,
  input  logic        cache_query_request_ready,
  output logic [31:0] cache_query_request_ip,
  input  logic        cache_query_response_valid,
  output logic        cache_query_response_ready,
  input  logic        cache_query_response_error,
  input  logic [47:0] cache_query_response_mac,
  output logic        cache_write_request_valid,
  input  logic        cache_write_request_ready,
  output logic [31:0] cache_write_request_ip,
  output logic [47:0] cache_write_request_mac,
  output logic        arp_tx_valid,
  input  logic        arp_tx_ready,
  output logic [31:0] arp_tx_tpa,
  input  logic        arp_rx_valid,
  output logic        arp_rx_ready,
  input  logic [31:0] arp_rx_spa,
  input  logic [47:0] arp_rx_sha,
  input  logic [31:0] local_ip,
  input  logic [31:0] subnet_mask,
  input  logic [31:0] gateway_ip
);

  localparam int unsigned ATT_W = (RETRY_COUNT < 2) ? 1 : $clog2(RETRY_COUNT + 1);
  localparam int unsigned TMR_W = $clog2(RETRY_INTERVAL + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUERY,
    S_WAIT_CACHE,
    S_SEND_REQ,
    S_WAIT_REPLY,
    S_RESPOND
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        next_hop_q, next_hop_d;
  logic [ATT_W-1:0]   attempts_q, attempts_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [47:0]        resp_mac_d;
  logic               resp_err_d;
  logic               wr_valid_d;
  logic [31:0]        wr_ip_d;
  logic [47:0]        wr_mac_d;

  logic               req_accept, rx_accept, rx_match, rx_load;
  logic               on_subnet, is_bcast;
  logic [31:0]        host_mask;

  // Request classification is done on the request-side inputs in the accept cycle.
  always_comb begin
    host_mask = ~subnet_mask;
    on_subnet = (arp_request_ip & subnet_mask) == (local_ip & subnet_mask);
    is_bcast  = (arp_request_ip == 32'hFFFF_FFFF) ||
                (on_subnet && ((arp_request_ip & host_mask) == host_mask));
  end

  always_comb begin
    req_accept = arp_request_valid && arp_request_ready;
    rx_accept  = arp_rx_valid && arp_rx_ready;
    rx_match   = rx_accept && (state_q == S_WAIT_REPLY) && (arp_rx_spa == next_hop_q);
`ifdef ARP_RESOLVER_LEARN_ALL_EN
    rx_load    = rx_accept;
`else
    rx_load    = rx_match;
`endif
  end

  // Next-state and next-register values for the resolve FSM and the learning slot.
  always_comb begin
    state_d    = state_q;
    next_hop_d = next_hop_q;
    attempts_d = attempts_q;
    timer_d    = timer_q;
    resp_mac_d = arp_response_mac;
    resp_err_d = arp_response_error;
    wr_valid_d = cache_write_request_valid;
    wr_ip_d    = cache_write_request_ip;
    wr_mac_d   = cache_write_request_mac;

    case (state_q)
      S_IDLE: begin
        if (req_accept) begin
          if (is_bcast) begin
            state_d    = S_RESPOND;
            resp_mac_d = 48'hFFFF_FFFF_FFFF;
            resp_err_d = 1'b0;
          end else if (on_subnet) begin
            next_hop_d = arp_request_ip;
            state_d    = S_QUERY;
          end else if (gateway_ip == 32'h0) begin
            state_d    = S_RESPOND;
            resp_mac_d = 48'h0;
            resp_err_d = 1'b1;
          end else begin
            next_hop_d = gateway_ip;
            state_d    = S_QUERY;
          end
        end
      end
      S_QUERY: begin
        if (cache_query_request_valid && cache_query_request_ready) state_d = S_WAIT_CACHE;
      end
      S_WAIT_CACHE: begin
        if (cache_query_response_valid && cache_query_response_ready) begin
          if (!cache_query_response_error) begin
            state_d    = S_RESPOND;
            resp_mac_d = cache_query_response_mac;
            resp_err_d = 1'b0;
          end else begin
            attempts_d = ATT_W'(RETRY_COUNT);
            state_d    = S_SEND_REQ;
          end
        end
      end
      S_SEND_REQ: begin
        if (arp_tx_valid && arp_tx_ready) begin
          attempts_d = attempts_q - ATT_W'(1);
          timer_d    = TMR_W'(RETRY_INTERVAL);
          state_d    = S_WAIT_REPLY;
        end
      end
      S_WAIT_REPLY: begin
        if (timer_q != '0) timer_d = timer_q - TMR_W'(1);
        // A matching reply wins over a timer expiring in the same cycle.
        if (rx_match) begin
          state_d    = S_RESPOND;
          resp_mac_d = arp_rx_sha;
          resp_err_d = 1'b0;
        end else if (timer_q <= TMR_W'(1)) begin
          if (attempts_q != '0) begin
            state_d = S_SEND_REQ;
          end else begin
            state_d    = S_RESPOND;
            resp_mac_d = 48'h0;
            resp_err_d = 1'b1;
          end
        end
      end
      S_RESPOND: begin
        if (arp_response_valid && arp_response_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Single-entry write slot; rx is only accepted while it is empty, so drain and load never collide.
    if (cache_write_request_valid && cache_write_request_ready) wr_valid_d = 1'b0;
    if (rx_load) begin
      wr_valid_d = 1'b1;
      wr_ip_d    = arp_rx_spa;
      wr_mac_d   = arp_rx_sha;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q                    <= S_IDLE;
      next_hop_q                 <= '0;
      attempts_q                 <= '0;
      timer_q                    <= '0;
      arp_request_ready          <= 1'b0;
      arp_response_valid         <= 1'b0;
      arp_response_error         <= 1'b0;
      arp_response_mac           <= '0;
      cache_query_request_valid  <= 1'b0;
      cache_query_request_ip     <= '0;
      cache_query_response_ready <= 1'b0;
      cache_write_request_valid  <= 1'b0;
      cache_write_request_ip     <= '0;
      cache_write_request_mac    <= '0;
      arp_tx_valid               <= 1'b0;
      arp_tx_tpa                 <= '0;
      arp_rx_ready               <= 1'b0;
    end else begin
      state_q                    <= state_d;
      next_hop_q                 <= next_hop_d;
      attempts_q                 <= attempts_d;
      timer_q                    <= timer_d;
      arp_request_ready          <= (state_d == S_IDLE);
      arp_response_valid         <= (state_d == S_RESPOND);
      arp_response_error         <= resp_err_d;
      arp_response_mac           <= resp_mac_d;
      cache_query_request_valid  <= (state_d == S_QUERY);
      cache_query_request_ip     <= next_hop_d;
      cache_query_response_ready <= (state_d == S_WAIT_CACHE);
      cache_write_request_valid  <= wr_valid_d;
      cache_write_request_ip     <= wr_ip_d;
      cache_write_request_mac    <= wr_mac_d;
      arp_tx_valid               <= (state_d == S_SEND_REQ);
      arp_tx_tpa                 <= next_hop_d;
      arp_rx_ready               <= !wr_valid_d;
    end
  end

endmodule
